rgb_pwm_bank: RTL and testbench

//   Multi-channel PWM generator for LED panel drive. It supersedes the fixed
//   3-channel comparator by owning its own PWM counter and holding a

---
 rtl/rgb_pwm_bank.sv | 161 ++++++++++++++++
 tb/tb_rgb_pwm_bank.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_bank.sv
// rgb_pwm_bank: multi-channel PWM generator for LED panel drive.
//
// A free-running counter supports two modes. Left-aligned is a sawtooth
// 0..CMAX. Centre-aligned is a triangle 0..CMAX..1. Each channel holds two
// levels: a pending level written by the pixel fetch logic, and an active
// level used by the comparator. Pending levels are copied to active only at
// a period boundary, and only after a commit request, so a colour update
// never tears mid-period.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous reset, active-low
//   en            run enable; 0 freezes the counter and blanks led
//   mode          0 = left-aligned, 1 = centre-aligned (taken at boundary)
//   wr_en         write wr_data into pending[wr_chan]
//   wr_chan       channel index; indices >= NCHAN are ignored
//   wr_data       level value
//   commit        request pending->active copy at the next boundary
//   commit_busy   commit requested, not yet applied
//   period_start  registered pulse in the first cycle of each period
//   pwmlvl        current counter value
//   led           registered PWM outputs
//
// Counter direction FSM
//   state    | meaning
//   DIR_UP   | counting towards CMAX (always the case in left-aligned mode)
//   DIR_DOWN | centre-aligned fall from CMAX-1 back towards 0

module rgb_pwm_bank #(
    parameter int PWM_WIDTH = 12,
    parameter int NCHAN     = 3,
    parameter int CHAN_W    = 2,
    parameter bit INVERT    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 wr_en,
    input  logic [CHAN_W-1:0]    wr_chan,
    input  logic [PWM_WIDTH-1:0] wr_data,
    input  logic                 commit,
    output logic                 commit_busy,
    output logic                 period_start,
    output logic [PWM_WIDTH-1:0] pwmlvl,
    output logic [NCHAN-1:0]     led
);

    localparam logic [PWM_WIDTH-1:0] CMAX     = '1;
    localparam logic [PWM_WIDTH-1:0] ONE      = PWM_WIDTH'(1);
    localparam logic [NCHAN-1:0]     INV_MASK = {NCHAN{INVERT}};

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
    dir_t                 dir_q, dir_d;
    logic                 mode_q, mode_d;
    logic                 pend_commit_q, pend_commit_d;
    logic                 period_start_q, period_start_d;
    logic [NCHAN-1:0]     led_q, led_d;
    logic [PWM_WIDTH-1:0] pending_q [NCHAN];
    logic [PWM_WIDTH-1:0] pending_d [NCHAN];
    logic [PWM_WIDTH-1:0] active_q  [NCHAN];
    logic [PWM_WIDTH-1:0] active_d  [NCHAN];
    logic                 boundary;
    logic [NCHAN-1:0]     led_raw;

    // Counter and direction. A boundary is any enabled edge that brings
    // the counter to zero, whichever mode produced it.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (en) begin
            if (!mode_q) begin
                cnt_d = (cnt_q == CMAX) ? '0 : cnt_q + ONE;
                dir_d = DIR_UP;
            end else if (dir_q == DIR_UP) begin
                if (cnt_q == CMAX) begin
                    cnt_d = cnt_q - ONE;
                    dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                cnt_d = cnt_q - ONE;
            end
            // Zero is held for one cycle only, so leave it climbing.
            if (cnt_d == '0) begin
                dir_d = DIR_UP;
            end
        end
    end

    assign boundary       = en && (cnt_d == '0);
    assign mode_d         = boundary ? mode : mode_q;
    assign period_start_d = boundary;

    // Level storage. The copy reads the pre-edge pending values, so a write
    // landing on the boundary edge is only seen at the following boundary.
    // A commit on the boundary edge re-arms the request after the copy.
    always_comb begin
        pending_d     = pending_q;
        active_d      = active_q;
        pend_commit_d = pend_commit_q;
        for (int i = 0; i < NCHAN; i++) begin
            if (wr_en && (wr_chan == CHAN_W'(i))) begin
                pending_d[i] = wr_data;
            end
        end
        if (boundary && pend_commit_q) begin
            active_d      = pending_q;
            pend_commit_d = 1'b0;
        end
        if (commit) begin
            pend_commit_d = 1'b1;
        end
    end

    // Enable gating sits before the output register, so blanking shows up
    // one cycle after en falls. Inversion is applied last.
    always_comb begin
        led_raw = '0;
        for (int i = 0; i < NCHAN; i++) begin
            led_raw[i] = active_q[i] > cnt_q;
        end
        led_d = (led_raw & {NCHAN{en}}) ^ INV_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            dir_q          <= DIR_UP;
            mode_q         <= 1'b0;
            pend_commit_q  <= 1'b0;
            period_start_q <= 1'b0;
            led_q          <= INV_MASK;
            for (int i = 0; i < NCHAN; i++) begin
                pending_q[i] <= '0;
                active_q[i]  <= '0;
            end
        end else begin
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            mode_q         <= mode_d;
            pend_commit_q  <= pend_commit_d;
            period_start_q <= period_start_d;
            led_q          <= led_d;
            pending_q      <= pending_d;
            active_q       <= active_d;
        end
    end

    assign commit_busy  = pend_commit_q;
    assign period_start = period_start_q;
    assign pwmlvl       = cnt_q;
    assign led          = led_q;

endmodule

// File: tb/tb_rgb_pwm_bank.sv
`timescale 1ns/1ps
module tb_rgb_pwm_bank;

    localparam int PW = 4;
    localparam int NC = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n, en, mode, wr_en, commit;
    logic [CW-1:0] wr_chan;
    logic [PW-1:0] wr_data;
    logic          commit_busy, period_start, busy_i, ps_i;
    logic [PW-1:0] pwmlvl, pwmlvl_i;
    logic [NC-1:0] led, led_i;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    rgb_pwm_bank #(.PWM_WIDTH(PW), .NCHAN(NC), .CHAN_W(CW), .INVERT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .wr_en(wr_en),
        .wr_chan(wr_chan), .wr_data(wr_data), .commit(commit),
        .commit_busy(commit_busy), .period_start(period_start),
        .pwmlvl(pwmlvl), .led(led)
    );

    rgb_pwm_bank #(.PWM_WIDTH(PW), .NCHAN(NC), .CHAN_W(CW), .INVERT(1'b1)) u_inv (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .wr_en(wr_en),
        .wr_chan(wr_chan), .wr_data(wr_data), .commit(commit),
        .commit_busy(busy_i), .period_start(ps_i),
        .pwmlvl(pwmlvl_i), .led(led_i)
    );

    // Stimulus changes at the falling edge; outputs are read there too.
    task automatic write_lvl(input int ch, input int val);
        wr_chan = CW'(ch);
        wr_data = PW'(val);
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic wait_ps(output bit ok);
        int g = 0;
        while (period_start !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        ok = (period_start === 1'b1);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_ps timeout: period_start=%b after %0d cycles, required 1", period_start, g);
        end
    endtask

    // Count led highs (and inverted-led lows) over one whole period,
    // starting at a period_start cycle and stopping at the next one.
    task automatic measure_period(output int h0, output int h1, output int h2,
                                  output int li0, output int len);
        bit ok;
        h0 = 0; h1 = 0; h2 = 0; li0 = 0; len = 0;
        wait_ps(ok);
        if (!ok) return;
        do begin
            h0  += int'(led[0]);
            h1  += int'(led[1]);
            h2  += int'(led[2]);
            li0 += int'(led_i[0] == 1'b0);
            len++;
            @(negedge clk);
        end while (period_start !== 1'b1 && len < 100);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; wr_en = 1'b0; commit = 1'b0;
        wr_chan = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (pwmlvl !== 4'd0) begin failures++; $display("FAIL reset_pwmlvl got=%0d exp=0", pwmlvl); end
        checks++;
        if (led !== 3'b000) begin failures++; $display("FAIL reset_led got=%b exp=000", led); end
        checks++;
        if (led_i !== 3'b111) begin failures++; $display("FAIL reset_led_inv got=%b exp=111", led_i); end
        checks++;
        if ({period_start, commit_busy, ps_i, busy_i, pwmlvl_i} !== 8'd0) begin
            failures++;
            $display("FAIL reset_flags got ps=%b busy=%b ps_i=%b busy_i=%b lvl_i=%0d exp all 0",
                     period_start, commit_busy, ps_i, busy_i, pwmlvl_i);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        checks++;
        if (pwmlvl !== 4'd1 || period_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_exit got lvl=%0d ps=%b exp lvl=1 ps=0", pwmlvl, period_start);
        end
    endtask

    task automatic test_left();
        int h0, h1, h2, li0, len, exp;
        bit ok;
        write_lvl(0, 5);
        do_commit();
        checks++;
        if (commit_busy !== 1'b1) begin failures++; $display("FAIL left_busy_set got=%b exp=1", commit_busy); end
        exp_q.push_back(5); exp_q.push_back(5); exp_q.push_back(16);
        wait_ps(ok);
        checks++;
        if (commit_busy !== 1'b0) begin failures++; $display("FAIL left_busy_clr got=%b exp=0", commit_busy); end
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp) begin failures++; $display("FAIL left_duty5 got=%0d exp=%0d", h0, exp); end
        exp = exp_q.pop_front(); checks++;
        if (li0 !== exp) begin failures++; $display("FAIL left_duty5_inv got=%0d exp=%0d", li0, exp); end
        exp = exp_q.pop_front(); checks++;
        if (len !== exp) begin failures++; $display("FAIL left_period got=%0d exp=%0d", len, exp); end

        write_lvl(0, 0);
        do_commit();
        exp_q.push_back(0);
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp) begin failures++; $display("FAIL left_duty0 got=%0d exp=%0d", h0, exp); end

        write_lvl(0, 15);
        do_commit();
        exp_q.push_back(15);
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp) begin failures++; $display("FAIL left_duty15 got=%0d exp=%0d", h0, exp); end
    endtask

    task automatic test_hold();
        int h0, h1, h2, li0, len, exp;
        bit ok;
        write_lvl(1, 8);
        for (int p = 0; p < 3; p++) exp_q.push_back(0);
        for (int p = 0; p < 3; p++) begin
            measure_period(h0, h1, h2, li0, len);
            exp = exp_q.pop_front(); checks++;
            if (h1 !== exp) begin failures++; $display("FAIL hold_uncommitted p%0d got=%0d exp=%0d", p, h1, exp); end
        end
        do_commit();
        checks++;
        if (commit_busy !== 1'b1) begin failures++; $display("FAIL hold_busy_set got=%b exp=1", commit_busy); end
        exp_q.push_back(8);
        wait_ps(ok);
        checks++;
        if (commit_busy !== 1'b0) begin failures++; $display("FAIL hold_busy_clr got=%b exp=0", commit_busy); end
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h1 !== exp) begin failures++; $display("FAIL hold_committed got=%0d exp=%0d", h1, exp); end

        // Channel index 3 is out of range and must not disturb anything.
        write_lvl(3, 9);
        do_commit();
        exp_q.push_back(15); exp_q.push_back(8); exp_q.push_back(0);
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp) begin failures++; $display("FAIL badchan_ch0 got=%0d exp=%0d", h0, exp); end
        exp = exp_q.pop_front(); checks++;
        if (h1 !== exp) begin failures++; $display("FAIL badchan_ch1 got=%0d exp=%0d", h1, exp); end
        exp = exp_q.pop_front(); checks++;
        if (h2 !== exp) begin failures++; $display("FAIL badchan_ch2 got=%0d exp=%0d", h2, exp); end
    endtask

    task automatic test_boundary();
        int h0, h1, h2, li0, len, exp, g;
        write_lvl(2, 10);
        g = 0;
        while (pwmlvl !== 4'd15 && g < 40) begin @(negedge clk); g++; end
        checks++;
        if (pwmlvl !== 4'd15) begin failures++; $display("FAIL bnd_reach_cmax got=%0d exp=15", pwmlvl); end
        wr_chan = 2'd2; wr_data = 4'd3; wr_en = 1'b1; commit = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; commit = 1'b0;
        checks++;
        if (commit_busy !== 1'b1 || period_start !== 1'b1) begin
            failures++;
            $display("FAIL bnd_still_pending got busy=%b ps=%b exp busy=1 ps=1", commit_busy, period_start);
        end
        exp_q.push_back(0); exp_q.push_back(3);
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h2 !== exp) begin failures++; $display("FAIL bnd_no_copy got=%0d exp=%0d", h2, exp); end
        checks++;
        if (commit_busy !== 1'b0) begin failures++; $display("FAIL bnd_busy_clr got=%b exp=0", commit_busy); end
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h2 !== exp) begin failures++; $display("FAIL bnd_late_copy got=%0d exp=%0d", h2, exp); end
    endtask

    task automatic test_back_to_back();
        int h0, h1, h2, li0, len, exp;
        bit ok;
        write_lvl(0, 2);
        do_commit();
        do_commit();
        write_lvl(0, 7);
        checks++;
        if (commit_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_set got=%b exp=1", commit_busy); end
        exp_q.push_back(7); exp_q.push_back(7);
        wait_ps(ok);
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp) begin failures++; $display("FAIL b2b_last_write got=%0d exp=%0d", h0, exp); end
        write_lvl(0, 4);
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp || commit_busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_single_apply got=%0d busy=%b exp=%0d busy=0", h0, commit_busy, exp);
        end
    endtask

    task automatic test_centre();
        int h0, h1, h2, li0, len, exp;
        mode = 1'b1;
        write_lvl(0, 4);
        do_commit();
        exp_q.push_back(30); exp_q.push_back(30); exp_q.push_back(7);
        exp_q.push_back(30); exp_q.push_back(7); exp_q.push_back(16);
        exp_q.push_back(16); exp_q.push_back(4);
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (len !== exp) begin failures++; $display("FAIL ctr_first_len got=%0d exp=%0d", len, exp); end
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (len !== exp) begin failures++; $display("FAIL ctr_len got=%0d exp=%0d", len, exp); end
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp) begin failures++; $display("FAIL ctr_duty got=%0d exp=%0d", h0, exp); end
        // led at pwmlvl==0 reflects the preceding cnt=1, which is inside the pulse.
        checks++;
        if (pwmlvl !== 4'd0 || led[0] !== 1'b1) begin
            failures++;
            $display("FAIL ctr_centred got lvl=%0d led0=%b exp lvl=0 led0=1", pwmlvl, led[0]);
        end
        mode = 1'b0;
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (len !== exp) begin failures++; $display("FAIL ctr_toggle_len got=%0d exp=%0d", len, exp); end
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp) begin failures++; $display("FAIL ctr_toggle_duty got=%0d exp=%0d", h0, exp); end
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (len !== exp) begin failures++; $display("FAIL ctr_back_left_len got=%0d exp=%0d", len, exp); end
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (len !== exp) begin failures++; $display("FAIL ctr_left_len got=%0d exp=%0d", len, exp); end
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp) begin failures++; $display("FAIL ctr_left_duty got=%0d exp=%0d", h0, exp); end
    endtask

    task automatic test_enable();
        int h0, h1, h2, li0, len, exp, g;
        bit ok, saw_ps;
        g = 0;
        while (pwmlvl !== 4'd2 && g < 40) begin @(negedge clk); g++; end
        checks++;
        if (pwmlvl !== 4'd2 || led[0] !== 1'b1) begin
            failures++;
            $display("FAIL en_pre got lvl=%0d led0=%b exp lvl=2 led0=1", pwmlvl, led[0]);
        end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (pwmlvl !== 4'd2 || led !== 3'b000 || led_i !== 3'b111) begin
            failures++;
            $display("FAIL en_blank got lvl=%0d led=%b led_i=%b exp lvl=2 led=000 led_i=111", pwmlvl, led, led_i);
        end
        write_lvl(0, 6);
        do_commit();
        saw_ps = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_ps |= period_start;
        end
        checks++;
        if (pwmlvl !== 4'd2 || saw_ps !== 1'b0 || commit_busy !== 1'b1) begin
            failures++;
            $display("FAIL en_frozen got lvl=%0d saw_ps=%b busy=%b exp lvl=2 saw_ps=0 busy=1", pwmlvl, saw_ps, commit_busy);
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (pwmlvl !== 4'd3) begin failures++; $display("FAIL en_resume got=%0d exp=3", pwmlvl); end
        exp_q.push_back(6); exp_q.push_back(6);
        wait_ps(ok);
        checks++;
        if (commit_busy !== 1'b0) begin failures++; $display("FAIL en_busy_clr got=%b exp=0", commit_busy); end
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp) begin failures++; $display("FAIL en_duty got=%0d exp=%0d", h0, exp); end
        exp = exp_q.pop_front(); checks++;
        if (li0 !== exp) begin failures++; $display("FAIL en_duty_inv got=%0d exp=%0d", li0, exp); end
    endtask

    task automatic test_reset_mid();
        int h0, h1, h2, li0, len, exp;
        write_lvl(0, 9);
        write_lvl(1, 9);
        do_commit();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (pwmlvl !== 4'd0 || led !== 3'b000 || led_i !== 3'b111 || period_start !== 1'b0 || commit_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got lvl=%0d led=%b led_i=%b ps=%b busy=%b exp 0 000 111 0 0",
                     pwmlvl, led, led_i, period_start, commit_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(3);
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if ((h0 | h1 | h2) !== exp) begin
            failures++;
            $display("FAIL rst_active_cleared got h0=%0d h1=%0d h2=%0d exp=%0d", h0, h1, h2, exp);
        end
        exp = exp_q.pop_front(); checks++;
        if (commit_busy !== 1'(exp)) begin failures++; $display("FAIL rst_commit_lost got=%b exp=%0d", commit_busy, exp); end
        do_commit();
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if ((h0 | h1 | h2) !== exp) begin
            failures++;
            $display("FAIL rst_pending_cleared got h0=%0d h1=%0d h2=%0d exp=%0d", h0, h1, h2, exp);
        end
        write_lvl(0, 3);
        do_commit();
        measure_period(h0, h1, h2, li0, len);
        exp = exp_q.pop_front(); checks++;
        if (h0 !== exp) begin failures++; $display("FAIL rst_recommit got=%0d exp=%0d", h0, exp); end
    endtask

    initial begin
        test_reset();
        test_left();
        test_hold();
        test_boundary();
        test_back_to_back();
        test_centre();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
